mdio_init_seq: RTL and testbench

- Parametrised successor to the fixed MDIO init block that sits between the SiTCP core's MDIO pins and the PCS/PMA management port.
- After reset it plays a parameter-defined list of Clause-22 register writes to the PHY at PHY_ADDR. Each write can optionally be read back and verified, with bounded retry.
- When the list finishes, it hands the MDIO bus over to the SiTCP core through an internal mux. COMPLETE and ERROR report the outcome.

---
 rtl/mdio_init_seq.sv | 185 ++++++++++++++++++
 tb/tb_mdio_init_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_init_seq.sv
// rtl/mdio_init_seq.sv - Clause-22 MDIO init sequencer with read-back verify and SiTCP bus handover
module mdio_init_seq #(
    parameter int unsigned CLK_DIV   = 64,
    parameter int unsigned NUM_CMD   = 1,
    parameter logic [((NUM_CMD > 0) ? NUM_CMD : 1)*22-1:0] CMD_LIST = 22'h000140,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] PHY_ADDR,
    output logic       MDC,
    output logic       MDIO_O,
    input  logic       MDIO_I,
    input  logic       SYS_MDC,
    input  logic       SYS_MDIO_OUT,
    input  logic       SYS_MDIO_OE,
    output logic       SYS_MDIO_IN,
    output logic [7:0] CMD_IDX,
    output logic       COMPLETE,
    output logic       ERROR
);

    localparam int unsigned NC    = (NUM_CMD > 0) ? NUM_CMD : 1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_CHECK, S_NEXT, S_GAP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mdc_q, mdc_d;
    logic             mdio_q, mdio_d;
    logic [6:0]       bit_q, bit_d;
    logic [7:0]       idx_q, idx_d;
    logic [3:0]       retry_q, retry_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             ta_q, ta_d;
    logic             complete_q, complete_d;
    logic             error_q, error_d;

    logic [21:0] entry;
    logic [63:0] fw;
    logic        div_wrap;
    logic        frame_end;
    logic        last;

    // select the active list entry {verify, regaddr, data}
    always_comb begin
        entry = '0;
        for (int i = 0; i < NC; i++) begin
            if (idx_q == 8'(i)) entry = CMD_LIST[22*i +: 22];
        end
    end

    assign div_wrap  = (div_q == DIV_MAX);
    assign frame_end = (bit_q == 7'd64) && mdc_q && div_wrap;
    assign last      = (idx_q == 8'(NC - 1));

    // sequencer: MDC/bit timing, frame selection, verify and retry decisions
    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        mdc_d      = 1'b0;
        bit_d      = '0;
        idx_d      = idx_q;
        retry_d    = retry_q;
        rd_data_d  = rd_data_q;
        ta_d       = ta_q;
        complete_d = complete_q;
        error_d    = error_q;
        mdio_d     = 1'b1;
        fw         = '1;

        case (state_q)
            S_IDLE: begin
                if (NUM_CMD == 0) begin
                    state_d = S_DONE;
                end else begin
                    // the idle cycle doubles as the first clock of frame bit 0
                    state_d = S_WR;
                    div_d   = DIV_W'(1);
                end
            end
            S_WR, S_RD: begin
                bit_d = bit_q;
                mdc_d = mdc_q;
                if (div_wrap) begin
                    mdc_d = ~mdc_q;
                    if (mdc_q) begin
                        bit_d = bit_q + 7'd1;
                    end else if (state_q == S_RD) begin
                        if (bit_q == 7'd47) ta_d = MDIO_I;
                        if (bit_q[6:4] == 3'b011) rd_data_d = {rd_data_q[14:0], MDIO_I};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                // bit 64 is the idle bit; the frame ends when its MDC high half expires
                if (frame_end) begin
                    bit_d = '0;
                    if (state_q == S_RD) state_d = S_CHECK;
                    else                 state_d = entry[21] ? S_RD : S_NEXT;
                end
            end
            S_CHECK: begin
                if ((rd_data_q == entry[15:0]) && !ta_q) begin
                    retry_d = '0;
                    state_d = S_NEXT;
                end else if (retry_q < 4'(MAX_RETRY)) begin
                    retry_d = retry_q + 4'd1;
                    state_d = S_GAP;
                end else begin
                    error_d = 1'b1;
                    retry_d = '0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last) begin
                    state_d    = S_DONE;
                    complete_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_WR;
                div_d   = DIV_W'(1);
            end
            S_DONE: begin
                complete_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RD) begin
            fw = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, entry[20:16], 2'b11, 16'hFFFF};
        end else begin
            fw = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, entry[20:16], 2'b10, entry[15:0]};
        end
        if ((state_d == S_WR || state_d == S_RD) && !bit_d[6]) begin
            mdio_d = fw[6'd63 - bit_d[5:0]];
        end
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            mdc_q      <= 1'b0;
            mdio_q     <= 1'b1;
            bit_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            rd_data_q  <= '0;
            ta_q       <= 1'b0;
            complete_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            mdc_q      <= mdc_d;
            mdio_q     <= mdio_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            rd_data_q  <= rd_data_d;
            ta_q       <= ta_d;
            complete_q <= complete_d;
            error_q    <= error_d;
        end
    end

    assign MDC         = complete_q ? SYS_MDC : mdc_q;
    assign MDIO_O      = complete_q ? (SYS_MDIO_OE ? SYS_MDIO_OUT : 1'b1) : mdio_q;
    assign SYS_MDIO_IN = complete_q ? MDIO_I : 1'b1;
    assign CMD_IDX     = idx_q;
    assign COMPLETE    = complete_q;
    assign ERROR       = error_q;

endmodule

// File: tb/tb_mdio_init_seq.sv
// tb/tb_mdio_init_seq.sv - self-checking bench for mdio_init_seq
`timescale 1ns/1ps
module tb_mdio_init_seq;

    localparam logic [43:0] LIST1 = {1'b0, 5'd0, 16'h1140, 1'b1, 5'd4, 16'h01E0};

    logic       clk = 1'b0;
    logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic [4:0] phy_addr = 5'd1;
    logic       sys_mdc = 1'b0, sys_out = 1'b0, sys_oe = 1'b0;
    logic       use_force = 1'b1, mdio_force = 1'b1, phy_drv;
    logic       mdio_i;

    logic       mdc0, mdo0, sin0, cmp0, err0;
    logic       mdc1, mdo1, sin1, cmp1, err1;
    logic       mdc2, mdo2, sin2, cmp2, err2;
    logic [7:0] idx0, idx1, idx2;

    logic        dec_rst = 1'b1, dec_en = 1'b0, sel = 1'b0;
    logic [31:0] exp_q[$];
    logic [16:0] rsp_q[$];
    int          total = 0;
    int          bad = 0;

    always #4 clk = ~clk;
    assign mdio_i = use_force ? mdio_force : phy_drv;

    mdio_init_seq u0 (
        .CLK(clk), .RST(rst0), .PHY_ADDR(phy_addr), .MDC(mdc0), .MDIO_O(mdo0), .MDIO_I(mdio_i),
        .SYS_MDC(sys_mdc), .SYS_MDIO_OUT(sys_out), .SYS_MDIO_OE(sys_oe), .SYS_MDIO_IN(sin0),
        .CMD_IDX(idx0), .COMPLETE(cmp0), .ERROR(err0));

    mdio_init_seq #(.CLK_DIV(2), .NUM_CMD(2), .CMD_LIST(LIST1), .MAX_RETRY(2)) u1 (
        .CLK(clk), .RST(rst1), .PHY_ADDR(phy_addr), .MDC(mdc1), .MDIO_O(mdo1), .MDIO_I(mdio_i),
        .SYS_MDC(sys_mdc), .SYS_MDIO_OUT(sys_out), .SYS_MDIO_OE(sys_oe), .SYS_MDIO_IN(sin1),
        .CMD_IDX(idx1), .COMPLETE(cmp1), .ERROR(err1));

    mdio_init_seq #(.CLK_DIV(2), .NUM_CMD(0)) u2 (
        .CLK(clk), .RST(rst2), .PHY_ADDR(phy_addr), .MDC(mdc2), .MDIO_O(mdo2), .MDIO_I(mdio_i),
        .SYS_MDC(sys_mdc), .SYS_MDIO_OUT(sys_out), .SYS_MDIO_OE(sys_oe), .SYS_MDIO_IN(sin2),
        .CMD_IDX(idx2), .COMPLETE(cmp2), .ERROR(err2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wr_f(input logic [4:0] ra, input logic [15:0] dat);
        return {2'b01, 2'b01, 5'd1, ra, 2'b10, dat};
    endfunction

    function automatic logic [31:0] rd_f(input logic [4:0] ra);
        return {2'b01, 2'b10, 5'd1, ra, 2'b11, 16'hFFFF};
    endfunction

    task automatic wait_cmp(input int which, input int lim, output int cnt);
        logic c;
        cnt = 0;
        c = (which == 0) ? cmp0 : cmp1;
        while (!c && cnt < lim) begin
            tick(1);
            cnt++;
            c = (which == 0) ? cmp0 : cmp1;
        end
        chk("complete_reached", {31'd0, c}, 32'd1);
    endtask

    // frame decoder and PHY model: samples MDIO_O on MDC rising edges, answers read frames
    initial begin
        logic        m, d, prev_mdc;
        logic [31:0] fw, e;
        logic [16:0] cur;
        int          ones, j;
        phy_drv = 1'b1;
        prev_mdc = 1'b0;
        ones = 0;
        j = -1;
        fw = '0;
        cur = 17'h1FFFF;
        forever begin
            @(negedge clk);
            m = sel ? mdc1 : mdc0;
            d = sel ? mdo1 : mdo0;
            if (dec_rst || !dec_en) begin
                prev_mdc = 1'b0;
                ones = 0;
                j = -1;
                phy_drv = 1'b1;
            end else begin
                if (m && !prev_mdc) begin
                    if (j < 0) begin
                        if (d) begin
                            ones++;
                        end else begin
                            chk("preamble_ones", (ones >= 32) ? 32 : ones, 32);
                            fw = '0;
                            j = 1;
                            ones = 0;
                        end
                    end else begin
                        fw[31-j] = d;
                        if (fw[29:28] == 2'b10) begin
                            if (j == 14) begin
                                cur = (rsp_q.size() > 0) ? rsp_q.pop_front() : 17'h1FFFF;
                                phy_drv = cur[16];
                            end else if (j >= 15 && j <= 30) begin
                                phy_drv = cur[30-j];
                            end
                        end
                        if (j == 31) begin
                            phy_drv = 1'b1;
                            if (exp_q.size() == 0) begin
                                chk("unexpected_frame", fw, 32'hFFFF_FFFF);
                            end else begin
                                e = exp_q.pop_front();
                                chk("frame", fw, e);
                            end
                            j = -1;
                        end else begin
                            j++;
                        end
                    end
                end
                prev_mdc = m;
            end
        end
    end

    typedef struct {
        logic smdc, soe, sout, mi;
        logic e_mdc, e_mo, e_sin;
    } mux_t;

    typedef struct {
        int          n;
        logic [16:0] r0, r1, r2;
        int          att;
        logic        err;
    } scn_t;

    initial begin
        mux_t mv[6];
        scn_t sv[4];
        int   cnt;

        mv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        mv[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        mv[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        mv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        mv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        mv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        sv[0] = '{1, 17'h001E0, 17'h1FFFF, 17'h1FFFF, 1, 1'b0};
        sv[1] = '{3, 17'h00000, 17'h00000, 17'h00000, 3, 1'b1};
        sv[2] = '{2, 17'h101E0, 17'h001E0, 17'h1FFFF, 2, 1'b0};
        sv[3] = '{2, 17'h001E1, 17'h001E0, 17'h1FFFF, 2, 1'b0};

        // reset state with hostile SiTCP-side inputs
        mdio_force = 1'b0;
        sys_mdc = 1'b1;
        sys_oe = 1'b1;
        sys_out = 1'b0;
        tick(3);
        chk("rst_mdc0", {31'd0, mdc0}, 32'd0);
        chk("rst_mdio0", {31'd0, mdo0}, 32'd1);
        chk("rst_sysin0", {31'd0, sin0}, 32'd1);
        chk("rst_cmp0", {31'd0, cmp0}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_idx0", {24'd0, idx0}, 32'd0);
        chk("rst_mdc1", {31'd0, mdc1}, 32'd0);
        chk("rst_mdio1", {31'd0, mdo1}, 32'd1);
        chk("rst_cmp2", {31'd0, cmp2}, 32'd0);
        sys_mdc = 1'b0;
        sys_oe = 1'b0;
        use_force = 1'b0;

        // single default write frame and its latency
        sel = 1'b0;
        dec_en = 1'b1;
        tick(1);
        dec_rst = 1'b0;
        exp_q.push_back(wr_f(5'd0, 16'h0140));
        rst0 = 1'b0;
        wait_cmp(0, 9000, cnt);
        total++;
        if (cnt < 8318 || cnt > 8322) begin
            bad++;
            $display("FAIL latency: got %0d cycles expected 8320+-2", cnt);
        end
        chk("t1_err", {31'd0, err0}, 32'd0);
        chk("t1_idx", {24'd0, idx0}, 32'd0);
        chk("t1_frames_left", exp_q.size(), 32'd0);

        // one-cycle reset during frame bit 40 while MDC is high
        rst0 = 1'b1;
        dec_rst = 1'b1;
        tick(2);
        chk("t2_cmp_cleared", {31'd0, cmp0}, 32'd0);
        dec_rst = 1'b0;
        exp_q.push_back(wr_f(5'd0, 16'h0140));
        rst0 = 1'b0;
        tick(40 * 128 + 100);
        chk("t2_mdc_high_bit40", {31'd0, mdc0}, 32'd1);
        rst0 = 1'b1;
        dec_rst = 1'b1;
        tick(1);
        chk("t2_abort_mdc", {31'd0, mdc0}, 32'd0);
        chk("t2_abort_mdio", {31'd0, mdo0}, 32'd1);
        chk("t2_abort_idx", {24'd0, idx0}, 32'd0);
        rst0 = 1'b0;
        dec_rst = 1'b0;
        wait_cmp(0, 9000, cnt);
        chk("t2_err", {31'd0, err0}, 32'd0);
        chk("t2_frames_left", exp_q.size(), 32'd0);

        // output mux after handover
        dec_en = 1'b0;
        use_force = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sys_mdc = mv[i].smdc;
            sys_oe = mv[i].soe;
            sys_out = mv[i].sout;
            mdio_force = mv[i].mi;
            #1;
            chk($sformatf("mux%0d_mdc", i), {31'd0, mdc0}, {31'd0, mv[i].e_mdc});
            chk($sformatf("mux%0d_mdio_o", i), {31'd0, mdo0}, {31'd0, mv[i].e_mo});
            chk($sformatf("mux%0d_sys_in", i), {31'd0, sin0}, {31'd0, mv[i].e_sin});
        end
        sys_mdc = 1'b0;
        sys_oe = 1'b0;
        sys_out = 1'b0;
        mdio_force = 1'b1;
        use_force = 1'b0;
        tick(1);

        // empty command list
        rst2 = 1'b0;
        tick(1);
        chk("n0_cmp_cycle1", {31'd0, cmp2}, 32'd0);
        tick(1);
        chk("n0_cmp_cycle2", {31'd0, cmp2}, 32'd1);
        chk("n0_idx", {24'd0, idx2}, 32'd0);
        chk("n0_err", {31'd0, err2}, 32'd0);

        // two-entry list with verify, scenario table
        sel = 1'b1;
        for (int s = 0; s < 4; s++) begin
            rst1 = 1'b1;
            dec_en = 1'b1;
            dec_rst = 1'b1;
            tick(2);
            dec_rst = 1'b0;
            exp_q.delete();
            rsp_q.delete();
            rsp_q.push_back(sv[s].r0);
            if (sv[s].n > 1) rsp_q.push_back(sv[s].r1);
            if (sv[s].n > 2) rsp_q.push_back(sv[s].r2);
            for (int a = 0; a < sv[s].att; a++) begin
                exp_q.push_back(wr_f(5'd4, 16'h01E0));
                exp_q.push_back(rd_f(5'd4));
            end
            exp_q.push_back(wr_f(5'd0, 16'h1140));
            rst1 = 1'b0;
            wait_cmp(1, 6000, cnt);
            chk($sformatf("s%0d_err", s), {31'd0, err1}, {31'd0, sv[s].err});
            chk($sformatf("s%0d_idx", s), {24'd0, idx1}, 32'd1);
            chk($sformatf("s%0d_frames_left", s), exp_q.size(), 32'd0);
            chk($sformatf("s%0d_reads_left", s), rsp_q.size(), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
